svaunit_clk_rst_gen: RTL and testbench



---
 rtl/svaunit_clk_rst_gen.sv | 162 ++++++++++++++++
 tb/tb_svaunit_clk_rst_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svaunit_clk_rst_gen.sv
// Clock and reset stimulus generator for SVAUnit benches: NUM_CH divided
// test clocks with programmable half-period/phase and a sequenced DUT reset.
module svaunit_clk_rst_gen #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8,
   parameter int RST_W  = 8,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   input  logic              start,
   input  logic [RST_W-1:0]  rst_len,
   input  logic              stop,
   output logic              dut_reset,
   output logic [NUM_CH-1:0] ch_clk,
   output logic [NUM_CH-1:0] ch_tick,
   output logic              running,
   output logic [31:0]       cycle_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RST_HOLD,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [RST_W-1:0]   r_hold;
   logic               r_dut_reset;
   logic               r_running;
   logic [31:0]        r_cycle_cnt;
   logic [NUM_CH-1:0]  r_ch_clk;
   logic [NUM_CH-1:0]  r_ch_tick;
   logic [DIV_W-1:0]   r_div   [NUM_CH];
   logic [DIV_W-1:0]   r_phase [NUM_CH];
   logic [DIV_W-1:0]   r_cnt   [NUM_CH];

   logic               w_cfg_we;
   logic               w_start_acc;
   logic               w_run_entry;
   logic               w_all_low;
   logic [DIV_W-1:0]   w_phase_eff [NUM_CH];
   logic [NUM_CH-1:0]  w_en;
   logic [NUM_CH-1:0]  w_wrap;
   logic [NUM_CH-1:0]  w_adv;

   assign cfg_ready   = (r_state == S_IDLE) && !reset;
   assign w_cfg_we    = cfg_valid && cfg_ready && (32'(cfg_ch) < 32'(NUM_CH));
   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_run_entry = (r_state == S_RST_HOLD) && (w_next == S_RUN);
   assign w_all_low   = (r_ch_clk == '0);

   assign dut_reset = r_dut_reset;
   assign running   = r_running;
   assign cycle_cnt = r_cycle_cnt;
   assign ch_clk    = r_ch_clk;
   assign ch_tick   = r_ch_tick;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_RST_HOLD;
         end
         S_RST_HOLD: begin
            if (stop) w_next = S_IDLE;
            else if (r_hold == RST_W'(1)) w_next = S_RUN;
         end
         S_RUN: begin
            if (stop) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_all_low) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // In DRAIN a channel only continues while high, so it finishes its high phase
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_en[i]   = (r_div[i] != '0);
         w_wrap[i] = (r_cnt[i] == r_div[i] - DIV_W'(1));
         w_adv[i]  = w_en[i] &&
                     ((r_state == S_RUN) ||
                      ((r_state == S_DRAIN) && r_ch_clk[i]));
         if (w_en[i] && (r_phase[i] >= r_div[i]))
            w_phase_eff[i] = r_div[i] - DIV_W'(1);
         else
            w_phase_eff[i] = r_phase[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_hold      <= '0;
         r_dut_reset <= 1'b1;
         r_running   <= 1'b0;
         r_cycle_cnt <= '0;
      end else begin
         r_state     <= w_next;
         r_dut_reset <= (w_next == S_IDLE) || (w_next == S_RST_HOLD);
         r_running   <= (w_next == S_RUN);
         if (w_start_acc) begin
            r_hold      <= (rst_len == '0) ? RST_W'(1) : rst_len;
            r_cycle_cnt <= '0;
         end else begin
            if (r_state == S_RST_HOLD)
               r_hold <= r_hold - RST_W'(1);
            if ((r_state == S_RUN) && (r_cycle_cnt != '1))
               r_cycle_cnt <= r_cycle_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            r_div[i]   <= '0;
            r_phase[i] <= '0;
         end else if (w_cfg_we && (cfg_ch == CH_W'(i))) begin
            r_div[i]   <= cfg_div;
            r_phase[i] <= cfg_phase;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            r_cnt[i]     <= '0;
            r_ch_clk[i]  <= 1'b0;
            r_ch_tick[i] <= 1'b0;
         end else if (w_run_entry) begin
            r_cnt[i]     <= w_phase_eff[i];
            r_ch_clk[i]  <= 1'b0;
            r_ch_tick[i] <= 1'b0;
         end else if (w_adv[i]) begin
            if (w_wrap[i]) begin
               r_cnt[i]     <= '0;
               r_ch_clk[i]  <= ~r_ch_clk[i];
               r_ch_tick[i] <= 1'b1;
            end else begin
               r_cnt[i]     <= r_cnt[i] + DIV_W'(1);
               r_ch_tick[i] <= 1'b0;
            end
         end else begin
            r_ch_tick[i] <= 1'b0;
            if (r_state == S_IDLE) r_ch_clk[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_svaunit_clk_rst_gen.sv
// Directed bench for svaunit_clk_rst_gen: sequencing, phase, drain and
// configuration rules against hand-derived waveforms.
module tb_svaunit_clk_rst_gen;

   localparam int NCH = 5;
   localparam int DW  = 8;
   localparam int RW  = 8;
   localparam int CW  = 3;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [CW-1:0]  cfg_ch = '0;
   logic [DW-1:0]  cfg_div = '0;
   logic [DW-1:0]  cfg_phase = '0;
   logic           start = 1'b0;
   logic [RW-1:0]  rst_len = '0;
   logic           stop = 1'b0;
   logic           dut_reset;
   logic [NCH-1:0] ch_clk;
   logic [NCH-1:0] ch_tick;
   logic           running;
   logic [31:0]    cycle_cnt;

   int n_vec = 0;
   int n_err = 0;

   svaunit_clk_rst_gen #(
      .NUM_CH(NCH), .DIV_W(DW), .RST_W(RW), .CH_W(CW)
   ) u_dut (
      .clock(clock), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
      .start(start), .rst_len(rst_len), .stop(stop),
      .dut_reset(dut_reset), .ch_clk(ch_clk), .ch_tick(ch_tick),
      .running(running), .cycle_cnt(cycle_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg(input int ch, input int dv, input int ph);
      cfg_valid = 1'b1;
      cfg_ch    = CW'(ch);
      cfg_div   = DW'(dv);
      cfg_phase = DW'(ph);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic go(input int len, output int hold);
      start   = 1'b1;
      rst_len = RW'(len);
      step();
      start = 1'b0;
      hold  = 0;
      while (dut_reset && hold < 40) begin
         step();
         hold++;
      end
   endtask

   initial begin
      int hold;
      int k;
      int ticks;
      logic [7:0] v0, v1, v2, t0;
      logic [NCH-1:0] acc;

      step();
      step();
      chk("rst_dut_reset", dut_reset, 1);
      chk("rst_ch_clk", ch_clk, 0);
      chk("rst_ch_tick", ch_tick, 0);
      chk("rst_running", running, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      reset = 1'b0;
      #1;
      chk("idle_cfg_ready", cfg_ready, 1);

      // div=2, rst_len=3
      cfg(0, 2, 0);
      go(3, hold);
      chk("t1_hold", hold, 3);
      chk("t1_running", running, 1);
      v0 = '0; t0 = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         v0 = {v0[6:0], ch_clk[0]};
         t0 = {t0[6:0], ch_tick[0]};
      end
      chk("t1_clk0", v0, 8'b01100110);
      chk("t1_tick0", t0, 8'b01010101);
      chk("t1_cycle_cnt", cycle_cnt, 8);

      cfg_valid = 1'b1; cfg_ch = 0; cfg_div = 7; cfg_phase = 0;
      chk("run_cfg_ready", cfg_ready, 0);
      v0 = '0; t0 = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         cfg_valid = 1'b0;
         v0 = {v0[6:0], ch_clk[0]};
         t0 = {t0[6:0], ch_tick[0]};
      end
      chk("run_cfg_clk0", v0, 8'b00000110);
      chk("run_cfg_tick0", t0, 8'b00000101);

      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t1_stop_running", running, 0);
      chk("t1_drain_ready", cfg_ready, 0);
      chk("t1_drain_dutrst", dut_reset, 0);
      step();
      chk("t1_idle_ready", cfg_ready, 1);
      chk("t1_idle_dutrst", dut_reset, 1);
      step();
      step();
      chk("t1_cnt_hold", cycle_cnt, 13);

      // phase relationships
      cfg(0, 4, 0);
      cfg(1, 4, 2);
      cfg(2, 4, 9);
      cfg(3, 0, 0);
      cfg(4, 0, 0);
      go(2, hold);
      chk("t2_hold", hold, 2);
      v0 = '0; v1 = '0; v2 = '0; acc = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         v0 = {v0[6:0], ch_clk[0]};
         v1 = {v1[6:0], ch_clk[1]};
         v2 = {v2[6:0], ch_clk[2]};
         acc = acc | ch_clk | ch_tick;
      end
      chk("t2_clk0", v0, 8'b00011110);
      chk("t2_clk1", v1, 8'b01111000);
      chk("t2_clk2_clamp", v2, 8'b11110000);
      chk("t2_ch34_idle", acc[4:3], 0);

      // stop as ch2 rises
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t2_stop_clk", ch_clk, 5'b00100);
      chk("t2_stop_running", running, 0);
      acc = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         acc = acc | ch_tick;
         chk("t2_drain_clk", ch_clk, 5'b00100);
      end
      chk("t2_drain_noticks", acc, 0);
      step();
      chk("t2_fall_clk", ch_clk, 0);
      chk("t2_fall_tick", ch_tick, 5'b00100);
      chk("t2_fall_ready", cfg_ready, 0);
      step();
      chk("t2_idle_ready", cfg_ready, 1);
      chk("t2_idle_tick", ch_tick, 0);

      // drain with div=5
      cfg(0, 5, 0);
      cfg(1, 0, 0);
      cfg(2, 0, 0);
      go(1, hold);
      chk("t3_hold", hold, 1);
      for (int i = 0; i < 6; i++) step();
      chk("t3_high", ch_clk[0], 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      k = 0; ticks = 0;
      while (ch_clk[0] && k < 20) begin
         step();
         k++;
         if (ch_tick[0]) ticks++;
      end
      chk("t3_drain_len", k, 3);
      chk("t3_drain_ticks", ticks, 1);
      chk("t3_fall_ready", cfg_ready, 0);
      step();
      chk("t3_idle_ready", cfg_ready, 1);
      acc = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         acc = acc | ch_clk | ch_tick;
      end
      chk("t3_quiet", acc, 0);

      // reset mid-RUN
      go(1, hold);
      step(); step(); step();
      reset = 1'b1;
      step();
      chk("r1_dut_reset", dut_reset, 1);
      chk("r1_running", running, 0);
      chk("r1_ch_clk", ch_clk, 0);
      chk("r1_ch_tick", ch_tick, 0);
      chk("r1_cycle_cnt", cycle_cnt, 0);
      chk("r1_cfg_ready", cfg_ready, 0);
      reset = 1'b0;
      #1;
      chk("r1_ready_after", cfg_ready, 1);

      // div cleared by reset; out-of-range channel write ignored
      cfg(5, 1, 0);
      go(0, hold);
      chk("r2_hold_len0", hold, 1);
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         acc = acc | ch_clk | ch_tick;
      end
      chk("r2_all_disabled", acc, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      chk("r2_idle_ready", cfg_ready, 1);

      // reset mid-RST_HOLD
      cfg(0, 2, 0);
      start = 1'b1; rst_len = 10;
      step();
      start = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      chk("r3_dut_reset", dut_reset, 1);
      chk("r3_running", running, 0);
      chk("r3_cfg_ready", cfg_ready, 0);
      reset = 1'b0;
      #1;

      // start wins over stop, then stop in RST_HOLD
      cfg(0, 2, 0);
      start = 1'b1; stop = 1'b1; rst_len = 5;
      step();
      start = 1'b0;
      chk("ss_hold_ready", cfg_ready, 0);
      chk("ss_hold_dutrst", dut_reset, 1);
      step();
      stop = 1'b0;
      chk("ss_idle_ready", cfg_ready, 1);
      acc = ch_clk | ch_tick;
      for (int i = 0; i < 4; i++) begin
         step();
         acc = acc | ch_clk | ch_tick;
      end
      chk("ss_no_toggle", acc, 0);
      chk("ss_running", running, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
